// File: rtl/calc_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : calc_arbiter                                                 |
// | Description : Round-robin front end sharing one pipelined q-datapath among |
// |               NUM_REQ requesters. Issues are tagged with the requester id, |
// |               results are queued in a credit-protected response FIFO.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module calc_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          artsn_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_c_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_d_i,
  output logic [DATA_WIDTH-1:0]         dp_a_o,
  output logic [DATA_WIDTH-1:0]         dp_b_o,
  output logic [DATA_WIDTH-1:0]         dp_c_o,
  output logic [DATA_WIDTH-1:0]         dp_d_o,
  output logic                          dp_valid_o,
  input  logic [DATA_WIDTH-1:0]         dp_q_i,
  input  logic                          dp_q_valid_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_q_o,
  output logic                          idle_o,
  output logic                          err_o
);

  localparam int                PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int                ENT_W      = ID_W + DATA_WIDTH;
  localparam logic [ID_W:0]     NREQ_EXT   = (ID_W + 1)'(NUM_REQ);
  localparam logic [ID_W-1:0]   LAST_ID    = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]  CREDIT_MAX = CNT_W'(FIFO_DEPTH);

  // Arbitration
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W:0]       scan_idx;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_found;
  logic [NUM_REQ-1:0]  grant_oh;
  logic                credit_ok;
  logic                accept;

  // Issue registers
  logic                  dp_valid_q;
  logic [DATA_WIDTH-1:0] dp_a_q, dp_b_q, dp_c_q, dp_d_q;
  logic [ID_W-1:0]       dp_id_q;

  // Tag delay line
  logic [LATENCY-1:0]  tag_v_q;
  logic [ID_W-1:0]     tag_id_q [LATENCY];
  logic                exp_valid;
  logic [ID_W-1:0]     exp_id;

  // Credits, response FIFO, error flag
  logic [CNT_W-1:0]    credit_q, credit_d;
  logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push;
  logic                pop;
  logic                err_q;

  assign credit_ok = (credit_q < CREDIT_MAX);
  assign accept    = |grant_oh;
  assign exp_valid = tag_v_q[LATENCY-1];
  assign exp_id    = tag_id_q[LATENCY-1];
  assign push      = exp_valid;
  assign pop       = rsp_valid_o & rsp_ready_i;

  // Scan requesters from the round-robin pointer upward, wrapping at NUM_REQ
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_q} + (ID_W + 1)'(k);
      if (scan_idx >= NREQ_EXT) begin
        scan_idx = scan_idx - NREQ_EXT;
      end
      if (!grant_found && req_valid_i[scan_idx[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[ID_W-1:0];
      end
    end
  end

  // One-hot grant; held low during reset so every output reads zero then
  always_comb begin
    grant_oh = '0;
    if (artsn_i && credit_ok && grant_found) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  // Next-state for pointer, credit counter and FIFO bookkeeping
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    credit_d = credit_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
    end
    case ({accept, pop})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      rr_ptr_q <= '0;
      credit_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_q | (dp_q_valid_i != exp_valid);
    end
  end

  // Register the granted operands; they hold when nothing is issued
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      dp_valid_q <= 1'b0;
      dp_a_q     <= '0;
      dp_b_q     <= '0;
      dp_c_q     <= '0;
      dp_d_q     <= '0;
      dp_id_q    <= '0;
    end else begin
      dp_valid_q <= accept;
      if (accept) begin
        dp_a_q  <= req_a_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        dp_b_q  <= req_b_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        dp_c_q  <= req_c_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        dp_d_q  <= req_d_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        dp_id_q <= grant_idx;
      end
    end
  end

  // Tag line: delays {valid, id} by LATENCY so it lines up with the result
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      tag_v_q <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      tag_v_q[0]  <= dp_valid_q;
      tag_id_q[0] <= dp_id_q;
      for (int s = 1; s < LATENCY; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end
    end
  end

  // Response FIFO storage; cleared on reset so the head reads zero
  always_ff @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        mem_q[e] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= {exp_id, dp_q_i};
    end
  end

  assign req_ready_o = grant_oh;
  assign dp_valid_o  = dp_valid_q;
  assign dp_a_o      = dp_a_q;
  assign dp_b_o      = dp_b_q;
  assign dp_c_o      = dp_c_q;
  assign dp_d_o      = dp_d_q;
  assign rsp_valid_o = (count_q != '0);
  assign rsp_id_o    = mem_q[rd_ptr_q][ENT_W-1:DATA_WIDTH];
  assign rsp_q_o     = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign idle_o      = (credit_q == '0);
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_calc_arbiter                                              |
// | Description : Self-checking bench for calc_arbiter with a behavioural      |
// |               datapath and a queue-based scoreboard.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_calc_arbiter;

  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int LAT = 3;
  localparam int FD  = 4;
  localparam int IDW = 2;

  typedef struct {
    int          r;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic [DW-1:0] d;
    logic [DW-1:0] q;
  } vec_t;

  logic              clk_i = 1'b0;
  logic              artsn_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR-1:0]     req_ready_o;
  logic [NR*DW-1:0]  req_a_i, req_b_i, req_c_i, req_d_i;
  logic [DW-1:0]     dp_a_o, dp_b_o, dp_c_o, dp_d_o;
  logic              dp_valid_o;
  logic [DW-1:0]     dp_q_i;
  logic              dp_q_valid_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [IDW-1:0]    rsp_id_o;
  logic [DW-1:0]     rsp_q_o;
  logic              idle_o;
  logic              err_o;
  logic              force_qv;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  calc_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .LATENCY    (LAT),
    .FIFO_DEPTH (FD),
    .ID_W       (IDW)
  ) dut (
    .clk_i        (clk_i),
    .artsn_i      (artsn_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_c_i      (req_c_i),
    .req_d_i      (req_d_i),
    .dp_a_o       (dp_a_o),
    .dp_b_o       (dp_b_o),
    .dp_c_o       (dp_c_o),
    .dp_d_o       (dp_d_o),
    .dp_valid_o   (dp_valid_o),
    .dp_q_i       (dp_q_i),
    .dp_q_valid_i (dp_q_valid_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_q_o      (rsp_q_o),
    .idle_o       (idle_o),
    .err_o        (err_o)
  );

  // q = ((a-b)*(3c+1) - 4d) >>> 1 in DW-bit signed arithmetic
  function automatic logic [DW-1:0] calc_q(input logic [DW-1:0] a, b, c, d);
    logic signed [DW-1:0] sa, sb, sc, sd, t;
    sa = a; sb = b; sc = c; sd = d;
    t  = (sa - sb) * (3 * sc + 1) - 4 * sd;
    return t >>> 1;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural datapath: LAT-cycle pipe sharing the reset
  logic          dpm_v [LAT];
  logic [DW-1:0] dpm_q [LAT];
  always @(posedge clk_i or negedge artsn_i) begin
    if (!artsn_i) begin
      for (int s = 0; s < LAT; s++) begin
        dpm_v[s] <= 1'b0;
        dpm_q[s] <= '0;
      end
    end else begin
      dpm_v[0] <= dp_valid_o;
      dpm_q[0] <= calc_q(dp_a_o, dp_b_o, dp_c_o, dp_d_o);
      for (int s = 1; s < LAT; s++) begin
        dpm_v[s] <= dpm_v[s-1];
        dpm_q[s] <= dpm_q[s-1];
      end
    end
  end
  assign dp_q_valid_i = dpm_v[LAT-1] | force_qv;
  assign dp_q_i       = dpm_q[LAT-1];

  // Scoreboard: expected grants, credit limit, issue contents, response order
  int                 m_ptr, m_out, m_g, m_i;
  logic [NR-1:0]      m_exp_rdy;
  logic               m_acc, m_pop, m_prev_acc;
  logic [4*DW-1:0]    m_prev_ops;
  logic [IDW-1:0]     m_gid;
  logic [IDW+DW-1:0]  m_q[$];
  int                 acc_log[$];
  int                 n_acc = 0;
  int                 n_pop = 0;

  always @(negedge clk_i) begin
    if (!artsn_i) begin
      m_ptr = 0; m_out = 0; m_prev_acc = 1'b0; m_prev_ops = '0;
      m_q.delete();
    end else begin
      m_exp_rdy = '0;
      if (m_out < FD) begin
        for (int k = 0; k < NR; k++) begin
          m_i = (m_ptr + k) % NR;
          if (m_exp_rdy == '0 && req_valid_i[m_i]) m_exp_rdy[m_i] = 1'b1;
        end
      end
      chk("req_ready", req_ready_o, m_exp_rdy);
      chk("dp_valid", dp_valid_o, m_prev_acc);
      if (m_prev_acc) chk("dp_operands", {dp_a_o, dp_b_o, dp_c_o, dp_d_o}, m_prev_ops);
      chk("idle", idle_o, m_out == 0);
      m_acc = |(req_valid_i & req_ready_o);
      m_pop = rsp_valid_o & rsp_ready_i;
      if (m_pop) begin
        n_pop++;
        if (m_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL rsp_unexpected: got id %0d q %0h expected no response", rsp_id_o, rsp_q_o);
        end else begin
          chk("rsp_id_q", {rsp_id_o, rsp_q_o}, m_q.pop_front());
        end
      end
      if (m_acc) begin
        m_g = 0;
        for (int k = 0; k < NR; k++) if (req_valid_i[k] & req_ready_o[k]) m_g = k;
        m_gid = m_g[IDW-1:0];
        m_prev_ops = {req_a_i[m_g*DW +: DW], req_b_i[m_g*DW +: DW],
                      req_c_i[m_g*DW +: DW], req_d_i[m_g*DW +: DW]};
        m_q.push_back({m_gid, calc_q(req_a_i[m_g*DW +: DW], req_b_i[m_g*DW +: DW],
                                     req_c_i[m_g*DW +: DW], req_d_i[m_g*DW +: DW])});
        m_ptr = (m_g + 1) % NR;
        acc_log.push_back(m_g);
        n_acc++;
      end
      m_prev_acc = m_acc;
      m_out = m_out + int'(m_acc) - int'(m_pop);
    end
  end

  task automatic rand_ops();
    for (int i = 0; i < NR; i++) begin
      req_a_i[i*DW +: DW] = $urandom;
      req_b_i[i*DW +: DW] = $urandom;
      req_c_i[i*DW +: DW] = $urandom_range(0, 40) - 20;
      req_d_i[i*DW +: DW] = $urandom;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_ready", req_ready_o, '0);
    chk("rst_dp_valid", dp_valid_o, 1'b0);
    chk("rst_dp_ops", {dp_a_o, dp_b_o, dp_c_o, dp_d_o}, '0);
    chk("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk("rst_rsp_id_q", {rsp_id_o, rsp_q_o}, '0);
    chk("rst_idle", idle_o, 1'b1);
    chk("rst_err", err_o, 1'b0);
  endtask

  task automatic drain(input int cycles);
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    repeat (cycles) @(posedge clk_i);
    #1;
    chk("drain_empty", m_q.size(), 0);
    @(negedge clk_i);
    chk("drain_idle", idle_o, 1'b1);
    chk("drain_rsp_valid", rsp_valid_o, 1'b0);
  endtask

  task automatic single_req(input vec_t v);
    logic [NR-1:0] oh;
    oh = '0;
    oh[v.r] = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    req_valid_i = oh;
    req_a_i[v.r*DW +: DW] = v.a;
    req_b_i[v.r*DW +: DW] = v.b;
    req_c_i[v.r*DW +: DW] = v.c;
    req_d_i[v.r*DW +: DW] = v.d;
    @(negedge clk_i);
    chk("vec_grant", req_ready_o, oh);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    @(negedge clk_i);
    chk("vec_dp_valid", dp_valid_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("vec_rsp_early", rsp_valid_o, 1'b0);
    end
    @(negedge clk_i);
    chk("vec_rsp_valid", rsp_valid_o, 1'b1);
    chk("vec_rsp_id", rsp_id_o, v.r[IDW-1:0]);
    chk("vec_rsp_q", rsp_q_o, v.q);
    @(negedge clk_i);
    chk("vec_idle_after", idle_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t vecs[6];
  int   n_acc0, n_pop0;

  initial begin
    vecs[0] = '{2, 10, 4, 2, 3, 15};
    vecs[1] = '{1, 1, 5, 1, 0, -8};
    vecs[2] = '{3, 3, 0, 0, 1, -1};
    vecs[3] = '{0, 0, 0, 0, 0, 0};
    vecs[4] = '{0, 32'h7fffffff, 32'hffffffff, 0, 0, 32'hc0000000};
    vecs[5] = '{1, 0, 0, 0, 1, -2};

    artsn_i = 1'b0; force_qv = 1'b0; rsp_ready_i = 1'b0;
    req_valid_i = '1;
    rand_ops();
    repeat (2) @(negedge clk_i);
    check_reset_outputs();
    @(posedge clk_i); #1;
    req_valid_i = '0;
    artsn_i = 1'b1;

    // Continuous requests from everyone: accept order follows the rotation
    acc_log.delete();
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk_i); #1;
      req_valid_i = '1;
      rand_ops();
    end
    @(posedge clk_i); #1;
    req_valid_i = '0;
    for (int i = 0; i < 8; i++) chk("rr_order", (acc_log.size() > i) ? acc_log[i] : -1, i % NR);
    drain(15);

    // Directed single-request vectors
    for (int v = 0; v < 6; v++) single_req(vecs[v]);

    // Backpressure: four credits then stall, then resume to 20 transactions
    n_acc0 = n_acc; n_pop0 = n_pop;
    rsp_ready_i = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk_i); #1;
      req_valid_i = '1;
      rand_ops();
    end
    @(negedge clk_i);
    chk("bp_accepts", n_acc - n_acc0, FD);
    chk("bp_ready_low", req_ready_o, '0);
    chk("bp_rsp_valid", rsp_valid_o, 1'b1);
    chk("bp_head", {rsp_id_o, rsp_q_o}, (m_q.size() > 0) ? m_q[0] : '1);
    repeat (3) @(negedge clk_i);
    chk("bp_head_held", {rsp_id_o, rsp_q_o}, (m_q.size() > 0) ? m_q[0] : '1);
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 200 && (n_acc - n_acc0) < 20; c++) begin
      @(posedge clk_i); #1;
      rand_ops();
    end
    req_valid_i = '0;
    chk("bp_total_accepts", n_acc - n_acc0, 20);
    drain(15);
    chk("bp_total_pops", n_pop - n_pop0, 20);

    // Randomised traffic against the scoreboard
    for (int c = 0; c < 400; c++) begin
      @(posedge clk_i); #1;
      req_valid_i = NR'($urandom);
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      rand_ops();
    end
    drain(20);
    chk("err_clean", err_o, 1'b0);

    // Spurious datapath valid with nothing in flight
    @(posedge clk_i); #1;
    force_qv = 1'b1;
    @(posedge clk_i); #1;
    force_qv = 1'b0;
    @(negedge clk_i);
    chk("err_set", err_o, 1'b1);
    chk("err_no_write", rsp_valid_o, 1'b0);
    repeat (4) @(negedge clk_i);
    chk("err_sticky", err_o, 1'b1);

    // Reset with two requests in flight
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b1;
    req_valid_i = '1;
    rand_ops();
    @(posedge clk_i); #1;
    rand_ops();
    @(posedge clk_i); #2;
    artsn_i = 1'b0;
    #1;
    check_reset_outputs();
    req_valid_i = '0;
    repeat (2) @(negedge clk_i);
    @(posedge clk_i); #1;
    artsn_i = 1'b1;
    n_pop0 = n_pop;
    @(posedge clk_i); #1;
    req_valid_i = '1;
    rand_ops();
    @(negedge clk_i);
    chk("post_reset_grant", req_ready_o, 4'b0001);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    drain(12);
    chk("post_reset_rsp_count", n_pop - n_pop0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/calc_arbiter.md
Name: calc_arbiter

Overview:
- Shares one instance of the pipelined q-datapath among NUM_REQ requesters. The datapath computes q = ((a-b)*(3c+1) - 4d) >>> 1.
- Round-robin arbitration selects one requester per cycle and issues its operands into the datapath.
- Each issue is tagged with the requester index. The tag travels in a delay line matched to the datapath latency.
- Results land in a credit-protected response FIFO and return through a valid/ready response port.

Parameters:
- DATA_WIDTH, 32, operand/result width (signed).
- NUM_REQ, 4, number of requesters (>=2).
- LATENCY, 3, cycles from dp_valid_o high to the matching dp_q_valid_i high.
- FIFO_DEPTH, 4, response FIFO entries; also the credit limit (power of 2, >=2).
- ID_W, $clog2(NUM_REQ), requester id width.

Ports:
- clk_i  in  1  clock, rising edge.
- artsn_i  in  1  asynchronous reset, active-low.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  one-hot grant/accept.
- req_a_i, req_b_i, req_c_i, req_d_i  in  NUM_REQ*DATA_WIDTH each  packed operands; requester i occupies slice i.
- dp_a_o, dp_b_o, dp_c_o, dp_d_o  out  DATA_WIDTH each  operands to the datapath.
- dp_valid_o  out  1  drives all four datapath valid inputs together.
- dp_q_i  in  DATA_WIDTH  datapath result.
- dp_q_valid_i  in  1  datapath result valid.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  response consumer ready.
- rsp_id_o  out  ID_W  requester index of the response.
- rsp_q_o  out  DATA_WIDTH  result.
- idle_o  out  1  no request in flight and FIFO empty.
- err_o  out  1  sticky tag/valid mismatch flag.

Behaviour:
- Reset (async, artsn_i low):
  - All outputs 0, except idle_o = 1.
  - Round-robin pointer = 0, FIFO empty, credit count = 0, tag line cleared, err_o = 0.
  - Reset mid-operation discards all in-flight and queued results. The datapath shares artsn_i.
- Arbitration:
  - credit_ok = (credit_cnt < FIFO_DEPTH).
  - When credit_ok, grant the first requester with req_valid_i set, scanning from pointer upward with wrap.
  - req_ready_o is the one-hot grant and is combinational from req_valid_i; requesters must not make valid depend on ready.
  - Accept = req_valid_i[i] & req_ready_o[i]. At most one accept per cycle.
  - On accept, pointer <= grant index + 1, wrapping NUM_REQ-1 -> 0. With no accept, pointer holds.
  - When credit_ok = 0, all req_ready_o = 0.
- Issue:
  - Operands of the granted slice are registered into dp_*_o.
  - dp_valid_o is high for exactly the cycle after accept.
  - dp_*_o hold their last value when no issue occurs.
  - Back-to-back issues are allowed: one per cycle.
- Tag line:
  - A LATENCY-stage shift of {valid, id}, loaded with {dp_valid_o, issued id}.
  - Its output, exp_valid/exp_id, is aligned with dp_q_valid_i.
- Response capture:
  - When exp_valid, write {exp_id, dp_q_i} to the FIFO. Capture is governed by exp_valid only.
  - If dp_q_valid_i != exp_valid in any cycle, err_o <= 1 and holds until reset.
- Credits:
  - credit_cnt counts in-flight plus queued entries.
  - +1 on accept, -1 on response pop, unchanged when both occur in the same cycle.
  - FIFO overflow is therefore impossible. Full-FIFO write plus pop in the same cycle is legal.
- Response port:
  - Show-ahead: rsp_valid_o = FIFO not empty, and rsp_id_o/rsp_q_o = head entry.
  - Pop on rsp_valid_o & rsp_ready_i.
  - Head is stable while rsp_valid_o & !rsp_ready_i.
  - FIFO pointers wrap modulo FIFO_DEPTH.
- Timing (LATENCY = 3):
  - Accept in cycle T -> dp_valid_o in T+1 -> dp_q_valid_i in T+4 -> FIFO write at end of T+4 -> rsp_valid_o in T+5.
  - Minimum round trip: 5 cycles.
- Ordering: responses return in global accept order.
- Arithmetic: none in the controller. Results pass through unmodified, signed two's complement, wrap per the datapath.
- idle_o = (credit_cnt == 0).

Test Plan:
- Single request on req 2 with a=10, b=4, c=2, d=3, rsp_ready_i=1 -> req_ready_o=4'b0100 in T, dp_valid_o in T+1, rsp_valid_o in T+5 with rsp_id_o=2, rsp_q_o=15, then idle_o=1.
- All 4 requesters valid continuously, rsp_ready_i=1 -> grants 0,1,2,3,0,1 on consecutive cycles with at most one per cycle; responses return with ids in the same order, each q matching the formula.
- rsp_ready_i=0, all valid -> exactly 4 accepts, then req_ready_o=0 and rsp_valid_o=1 with head held. Raise rsp_ready_i -> one pop per cycle, accepts resume; no loss or duplication across 20 transactions.
- Signed/odd cases: (a=1, b=5, c=1, d=0) -> q=-8; (a=3, b=0, c=0, d=1) -> q=-1; (a=0, b=0, c=0, d=0) -> q=0.
- Force dp_q_valid_i=1 for one cycle with nothing in flight -> err_o=1 and stays 1; FIFO unchanged (rsp_valid_o=0).
- Two requests in flight, pull artsn_i low mid-cycle -> all outputs 0 immediately. After release: idle_o=1, no stale response, and the first grant with all requesters valid goes to req 0.
